// File: rtl/sample_buffer.sv
// First-word-fall-through sample FIFO between the fast-clock sampling stage and a consumer.
// Tracks per-acquisition accepted word count and a sticky overflow flag; a drop halts capture.
module sample_buffer #(
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acq_enable,
    input  logic [15:0]           in_data,
    input  logic                  in_valid,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [31:0]           word_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [15:0]           mem [DEPTH];
    logic [LW-1:0]         level_next;
    logic                  start;
    logic                  pop;
    logic                  push_try;
    logic                  push_ok;
    logic                  drop;
    logic                  full;

    // Event decode and next-state logic
    always_comb begin
        state_next = state;
        level_next = level;
        start      = (state == ST_IDLE) && acq_enable;
        pop        = out_valid && out_ready && !start;
        push_try   = in_valid && (state == ST_RUN);
        full       = (level == LW'(DEPTH));
        push_ok    = push_try && (!full || pop);
        drop       = push_try && full && !pop;

        case (state)
            ST_IDLE: if (acq_enable) state_next = ST_RUN;
            ST_RUN: begin
                if (!acq_enable)  state_next = ST_IDLE;
                else if (drop)    state_next = ST_HALT;
            end
            ST_HALT: if (!acq_enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        case ({push_ok, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Pointers, occupancy and acquisition statistics
    always_ff @(posedge clk) begin
        if (rst || start) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level     <= level_next;
            out_valid <= (level_next != '0);
            if (drop) overflow <= 1'b1;
            if (push_ok && (word_count != 32'hFFFF_FFFF))
                word_count <= word_count + 32'd1;
        end
    end

    // Storage is not reset; out_data is only meaningful while out_valid is high
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= in_data;
    end

    assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_sample_buffer.sv
// Directed self-checking bench for sample_buffer at DEPTH_LOG2=5.
module tb_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        acq_enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  level;
    logic        overflow;
    logic [31:0] word_count;

    int n_cmp  = 0;
    int n_fail = 0;

    sample_buffer #(.DEPTH_LOG2(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .acq_enable (acq_enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_rd;
        int pushed;
        int cyc;

        rst = 1'b1; acq_enable = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        rst = 1'b0;

        // Basic flow
        acq_enable = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_data = 16'h1111; step();
        chk("basic_d0", 32'(out_data), 32'h1111);
        chk("basic_lvl0", 32'(level), 32'd1);
        in_data = 16'h2222; step();
        chk("basic_d1", 32'(out_data), 32'h2222);
        chk("basic_lvl1", 32'(level), 32'd1);
        in_data = 16'h3333; step();
        chk("basic_d2", 32'(out_data), 32'h3333);
        chk("basic_lvl2", 32'(level), 32'd1);
        in_valid = 1'b0; step();
        chk("basic_empty", 32'(out_valid), 32'd0);
        chk("basic_wc", word_count, 32'd3);
        chk("basic_ovf", 32'(overflow), 32'd0);

        // Fill and overflow
        acq_enable = 1'b0; step();
        out_ready = 1'b0; acq_enable = 1'b1; step();
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 16'(i); step();
        end
        chk("fill_lvl32", 32'(level), 32'd32);
        chk("fill_ovf0", 32'(overflow), 32'd0);
        in_data = 16'd32; step();
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_lvl", 32'(level), 32'd32);
        chk("drop_wc", word_count, 32'd32);
        in_data = 16'h0099; step();
        chk("halt_lvl", 32'(level), 32'd32);
        chk("halt_wc", word_count, 32'd32);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data", 32'(out_data), 32'(i));
            step();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Restart after overflow; in_valid on the start cycle is ignored
        acq_enable = 1'b0; step();
        chk("idle_ovf_sticky", 32'(overflow), 32'd1);
        acq_enable = 1'b1; in_valid = 1'b1; in_data = 16'h5555; step();
        chk("restart_lvl", 32'(level), 32'd0);
        chk("restart_ovf", 32'(overflow), 32'd0);
        chk("restart_wc", word_count, 32'd0);

        // Full with simultaneous pop
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_data = 16'(100 + i); step();
        end
        chk("full_lvl", 32'(level), 32'd32);
        in_data = 16'hABCD; out_ready = 1'b1; step();
        chk("fullpop_lvl", 32'(level), 32'd32);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_wc", word_count, 32'd33);
        in_valid = 1'b0;
        for (int i = 1; i < 32; i++) begin
            chk("fullpop_drain", 32'(out_data), 32'(100 + i));
            step();
        end
        chk("fullpop_last", 32'(out_data), 32'hABCD);
        step();
        chk("fullpop_empty", 32'(level), 32'd0);

        // Wrap-around: pushes every other cycle, out_ready toggling every cycle
        acq_enable = 1'b0; step();
        acq_enable = 1'b1; step();
        exp_rd = 0; pushed = 0; cyc = 0;
        while ((exp_rd < 100) && (cyc < 1000)) begin
            in_valid  = (pushed < 100) && (cyc % 2 == 0);
            in_data   = 16'(16'h4000 + pushed);
            out_ready = (cyc % 4 < 2);
            if (out_valid && out_ready) begin
                chk("wrap_data", 32'(out_data), 32'(16'h4000 + exp_rd));
                exp_rd++;
            end
            if (in_valid) pushed++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("wrap_received", 32'(exp_rd), 32'd100);
        chk("wrap_wc", word_count, 32'd100);
        chk("wrap_lvl", 32'(level), 32'd0);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // Reset mid-run
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'(16'h0A00 + i); step();
        end
        chk("mid_lvl10", 32'(level), 32'd10);
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_lvl", 32'(level), 32'd0);
        chk("mid_rst_wc", word_count, 32'd0);
        step();
        in_valid = 1'b1; in_data = 16'h7777; step();
        in_valid = 1'b0;
        chk("resume_data", 32'(out_data), 32'h7777);
        chk("resume_lvl", 32'(level), 32'd1);
        chk("resume_wc", word_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
